// File: rtl/memaccess_if.sv
// Bundle of execute-side, data-bus and writeback-side signals of the memory-access stage.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready toward execute, dreq_valid/dresp_data_ok toward the bus, out_valid/out_ready toward writeback.
interface memaccess_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_fun3;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [4:0]  in_rd;
  logic        in_rd_en;
  logic        flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_en;
  logic [63:0] out_data;
  logic [3:0]  out_code;

  // Stage side
  modport slave (
    input  in_valid, in_pc, in_is_load, in_is_store, in_fun3, in_addr, in_wdata, in_rd, in_rd_en, flush,
    input  dresp_data_ok, dresp_data, out_ready,
    output in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output out_valid, out_pc, out_rd, out_rd_en, out_data, out_code
  );

  // Environment side (execute, bus, writeback)
  modport master (
    output in_valid, in_pc, in_is_load, in_is_store, in_fun3, in_addr, in_wdata, in_rd, in_rd_en, flush,
    output dresp_data_ok, dresp_data, out_ready,
    input  in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  out_valid, out_pc, out_rd, out_rd_en, out_data, out_code
  );
endinterface

// File: rtl/memaccess.sv
// Memory-access stage: one bus transaction per load/store, load align/extend, store strobe/lane shift.
// Latency: non-memory result 1 cycle after accept; memory result 1 cycle after dresp_data_ok (min 2).
// Backpressure: result held while out_ready=0, in_ready only in IDLE or HOLD&out_ready; MEMACCESS_MISALIGN_TRAP_EN enables misalignment traps.
module memaccess (
  input logic        clk,
  input logic        rst,
  memaccess_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_HOLD, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_in_ready;
  logic        w_dreq_vld;
  logic        w_out_vld;
  logic        w_accept;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_bus_done;

  logic [63:0] r_pc;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [2:0]  r_fun3;
  logic        r_is_load;
  logic        r_is_store;
  logic [4:0]  r_rd;
  logic        r_rd_en;
  logic [63:0] r_data;
  logic [3:0]  r_code;

  logic [5:0]  w_shift;
  logic [63:0] w_lane;
  logic [63:0] w_load;
  logic [7:0]  w_mask;

  assign w_is_mem   = bus.in_is_load | bus.in_is_store;
  assign w_accept   = bus.in_valid & w_in_ready & ~bus.flush;
  // A response that arrives in BUS without a flush produces the writeback result
  assign w_bus_done = (r_state == S_BUS) & bus.dresp_data_ok & ~bus.flush;

`ifdef MEMACCESS_MISALIGN_TRAP_EN
  logic [2:0] w_align_mask;
  // Low address bits that must be zero for the requested width (B:000 H:001 W:011 D:111)
  assign w_align_mask = {bus.in_fun3[1] & bus.in_fun3[0], bus.in_fun3[1], |bus.in_fun3[1:0]};
  assign w_misalign   = w_is_mem & |(bus.in_addr[2:0] & w_align_mask);
`else
  assign w_misalign   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and handshake outputs; flush wins over a same-cycle accept
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_dreq_vld = 1'b0;
    w_out_vld  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
      end
      S_BUS: begin
        w_dreq_vld = 1'b1;
        if (bus.dresp_data_ok) w_next = bus.flush ? S_IDLE : S_HOLD;
        else if (bus.flush)    w_next = S_DRAIN;
      end
      S_HOLD: begin
        w_out_vld  = 1'b1;
        w_in_ready = bus.out_ready;
        if (bus.flush || bus.out_ready) w_next = S_IDLE;
      end
      S_DRAIN: begin
        w_dreq_vld = 1'b1;
        if (bus.dresp_data_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.in_valid && w_in_ready && !bus.flush)
      w_next = (w_is_mem && !w_misalign) ? S_BUS : S_HOLD;
  end

  // Result and request registers: captured on accept, load data merged on bus completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_fun3     <= '0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_rd       <= '0;
      r_rd_en    <= 1'b0;
      r_data     <= '0;
      r_code     <= '0;
    end else if (w_accept) begin
      r_pc       <= bus.in_pc;
      r_addr     <= bus.in_addr;
      r_wdata    <= bus.in_wdata;
      r_fun3     <= bus.in_fun3;
      r_is_load  <= bus.in_is_load;
      r_is_store <= bus.in_is_store;
      r_rd       <= bus.in_rd;
      r_data     <= bus.in_addr;
      if (w_misalign) begin
        r_rd_en <= 1'b0;
        r_code  <= bus.in_is_load ? 4'd4 : 4'd6;
      end else begin
        r_rd_en <= bus.in_rd_en;
        r_code  <= 4'd0;
      end
    end else if (w_bus_done) begin
      r_data <= r_is_load ? w_load : 64'd0;
      if (r_is_store) r_rd_en <= 1'b0;
    end
  end

  // Byte lane of the access within the 8-byte bus word
  assign w_shift = {r_addr[2:0], 3'b000};
  assign w_lane  = bus.dresp_data >> w_shift;

  // Load width selection with sign (fun3[2]=0) or zero extension
  always_comb begin
    w_load = '0;
    case (r_fun3[1:0])
      2'd0: w_load = r_fun3[2] ? {56'd0, w_lane[7:0]}  : {{56{w_lane[7]}},  w_lane[7:0]};
      2'd1: w_load = r_fun3[2] ? {48'd0, w_lane[15:0]} : {{48{w_lane[15]}}, w_lane[15:0]};
      2'd2: w_load = r_fun3[2] ? {32'd0, w_lane[31:0]} : {{32{w_lane[31]}}, w_lane[31:0]};
      default: w_load = w_lane;
    endcase
  end

  // Byte mask of the access width before lane shift
  always_comb begin
    w_mask = 8'h00;
    case (r_fun3[1:0])
      2'd0: w_mask = 8'h01;
      2'd1: w_mask = 8'h03;
      2'd2: w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.dreq_valid  = w_dreq_vld;
  assign bus.dreq_addr   = r_addr;
  assign bus.dreq_size   = {1'b0, r_fun3[1:0]};
  // Lanes shifted past byte 7 fall off the 8-bit strobe and 64-bit data
  assign bus.dreq_strobe = r_is_store ? (w_mask << r_addr[2:0]) : 8'h00;
  assign bus.dreq_data   = r_wdata << w_shift;
  assign bus.out_valid   = w_out_vld;
  assign bus.out_pc      = r_pc;
  assign bus.out_rd      = r_rd;
  assign bus.out_rd_en   = r_rd_en;
  assign bus.out_data    = r_data;
  assign bus.out_code    = r_code;

endmodule

// File: tb/tb_memaccess.sv
// Directed bench for memaccess with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises out_ready stalls, delayed dresp_data_ok and flush drain.
module tb_memaccess;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  memaccess_if mif();

  memaccess dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd, input logic en);
    mif.in_valid    = 1'b1;
    mif.in_pc       = pc;
    mif.in_is_load  = ld;
    mif.in_is_store = st;
    mif.in_fun3     = f3;
    mif.in_addr     = addr;
    mif.in_wdata    = wd;
    mif.in_rd       = rd;
    mif.in_rd_en    = en;
  endtask

  task automatic respond(input logic [63:0] rdata);
    mif.dresp_data_ok = 1'b1;
    mif.dresp_data    = rdata;
    tick();
    mif.dresp_data_ok = 1'b0;
  endtask

  // Single-cycle response load followed by return to IDLE
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp);
    drive(64'h200, 1'b1, 1'b0, f3, addr, 64'd0, 5'd7, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    check({tag, "_dreq_vld"}, mif.dreq_valid, 1'b1);
    check({tag, "_dreq_addr"}, mif.dreq_addr, addr);
    check({tag, "_strobe"}, mif.dreq_strobe, 8'h00);
    respond(rdata);
    check({tag, "_out_vld"}, mif.out_valid, 1'b1);
    check({tag, "_data"}, mif.out_data, exp);
    check({tag, "_code"}, mif.out_code, 4'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    mif.in_valid = 1'b0; mif.in_pc = '0; mif.in_is_load = 1'b0; mif.in_is_store = 1'b0;
    mif.in_fun3 = '0; mif.in_addr = '0; mif.in_wdata = '0; mif.in_rd = '0; mif.in_rd_en = 1'b0;
    mif.flush = 1'b0; mif.dresp_data_ok = 1'b0; mif.dresp_data = '0; mif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", mif.in_ready, 1'b1);
    check("rst_dreq_vld", mif.dreq_valid, 1'b0);
    check("rst_strobe", mif.dreq_strobe, 8'h00);
    check("rst_out_vld", mif.out_valid, 1'b0);
    check("rst_out_data", mif.out_data, 64'd0);
    check("rst_out_code", mif.out_code, 4'd0);
    rst = 1'b1;
    tick();

    // Non-memory, then back-to-back
    mif.out_ready = 1'b1;
    drive(64'h100, 1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1);
    tick();
    check("alu_out_vld", mif.out_valid, 1'b1);
    check("alu_data", mif.out_data, 64'h1234);
    check("alu_rd", mif.out_rd, 5'd5);
    check("alu_pc", mif.out_pc, 64'h100);
    check("alu_rd_en", mif.out_rd_en, 1'b1);
    check("alu_in_ready", mif.in_ready, 1'b1);
    drive(64'h104, 1'b0, 1'b0, 3'd0, 64'h5678, 64'd0, 5'd6, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    check("b2b_data", mif.out_data, 64'h5678);
    check("b2b_pc", mif.out_pc, 64'h104);
    check("b2b_out_vld", mif.out_valid, 1'b1);
    tick();
    check("alu_idle_vld", mif.out_valid, 1'b0);

    // Loads
    run_load("lb",  3'd0, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    run_load("lbu", 3'd4, 64'h1003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    run_load("lh",  3'd1, 64'h0006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    run_load("lwu", 3'd6, 64'h0004, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);

    // SH at 0x2002
    drive(64'h300, 1'b0, 1'b1, 3'd1, 64'h2002, 64'hBEEF, 5'd3, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    check("sh_strobe", mif.dreq_strobe, 8'h0C);
    check("sh_wdata", mif.dreq_data, 64'h0000_0000_BEEF_0000);
    check("sh_size", mif.dreq_size, 3'd1);
    respond(64'hFFFF_FFFF_FFFF_FFFF);
    check("sh_out_vld", mif.out_valid, 1'b1);
    check("sh_rd_en", mif.out_rd_en, 1'b0);
    check("sh_data", mif.out_data, 64'd0);
    tick();

`ifdef MEMACCESS_MISALIGN_TRAP_EN
    drive(64'h400, 1'b1, 1'b0, 3'd2, 64'h1002, 64'd0, 5'd9, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    check("mlw_dreq_vld", mif.dreq_valid, 1'b0);
    check("mlw_out_vld", mif.out_valid, 1'b1);
    check("mlw_code", mif.out_code, 4'd4);
    check("mlw_data", mif.out_data, 64'h1002);
    check("mlw_rd_en", mif.out_rd_en, 1'b0);
    drive(64'h404, 1'b0, 1'b1, 3'd2, 64'h1006, 64'hAABB_CCDD, 5'd9, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    check("msw_dreq_vld", mif.dreq_valid, 1'b0);
    check("msw_code", mif.out_code, 4'd6);
    check("msw_data", mif.out_data, 64'h1006);
    tick();
`else
    drive(64'h400, 1'b0, 1'b1, 3'd2, 64'h1006, 64'hAABB_CCDD, 5'd9, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    check("msw_dreq_vld", mif.dreq_valid, 1'b1);
    check("msw_strobe", mif.dreq_strobe, 8'hC0);
    check("msw_wdata", mif.dreq_data, 64'hCCDD_0000_0000_0000);
    respond(64'd0);
    check("msw_code", mif.out_code, 4'd0);
    tick();
`endif

    // LW with response delayed 5 cycles, then writeback stall
    drive(64'h500, 1'b1, 1'b0, 3'd2, 64'h3004, 64'd0, 5'd11, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("dly_dreq_vld", mif.dreq_valid, 1'b1);
      check("dly_dreq_addr", mif.dreq_addr, 64'h3004);
      check("dly_dreq_size", mif.dreq_size, 3'd2);
      check("dly_out_vld", mif.out_valid, 1'b0);
      if (i == 5) begin
        mif.out_ready     = 1'b0;
        mif.dresp_data_ok = 1'b1;
        mif.dresp_data    = 64'h89AB_CDEF_0000_0000;
      end
      tick();
    end
    mif.dresp_data_ok = 1'b0;
    check("dly_dreq_done", mif.dreq_valid, 1'b0);
    drive(64'h600, 1'b0, 1'b0, 3'd0, 64'h9999, 64'd0, 5'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall_out_vld", mif.out_valid, 1'b1);
      check("stall_data", mif.out_data, 64'hFFFF_FFFF_89AB_CDEF);
      check("stall_rd", mif.out_rd, 5'd11);
      check("stall_in_ready", mif.in_ready, 1'b0);
      tick();
    end
    mif.in_valid  = 1'b0;
    mif.out_ready = 1'b1;
    tick();
    check("stall_release", mif.out_valid, 1'b0);

    // Flush in 2nd BUS cycle, response 3 cycles later
    drive(64'h700, 1'b1, 1'b0, 3'd3, 64'h4000, 64'd0, 5'd12, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    check("fl_bus1", mif.dreq_valid, 1'b1);
    tick();
    mif.flush = 1'b1;
    tick();
    mif.flush = 1'b0;
    check("fl_drain_req", mif.dreq_valid, 1'b1);
    check("fl_drain_rdy", mif.in_ready, 1'b0);
    check("fl_drain_vld", mif.out_valid, 1'b0);
    tick();
    check("fl_drain2_vld", mif.out_valid, 1'b0);
    tick();
    check("fl_drain3_req", mif.dreq_valid, 1'b1);
    respond(64'h1111_2222_3333_4444);
    check("fl_done_vld", mif.out_valid, 1'b0);
    check("fl_done_rdy", mif.in_ready, 1'b1);
    check("fl_done_req", mif.dreq_valid, 1'b0);
    tick();
    check("fl_late_vld", mif.out_valid, 1'b0);

    // Flush while holding a result
    mif.out_ready = 1'b0;
    drive(64'h800, 1'b0, 1'b0, 3'd0, 64'h77, 64'd0, 5'd2, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    check("flh_vld", mif.out_valid, 1'b1);
    mif.flush = 1'b1;
    tick();
    mif.flush = 1'b0;
    check("flh_drop", mif.out_valid, 1'b0);
    check("flh_rdy", mif.in_ready, 1'b1);

    // Flush beats a simultaneous accept
    mif.out_ready = 1'b1;
    mif.flush = 1'b1;
    drive(64'h900, 1'b1, 1'b0, 3'd3, 64'h5000, 64'd0, 5'd4, 1'b1);
    tick();
    mif.in_valid = 1'b0;
    mif.flush = 1'b0;
    check("flp_dreq", mif.dreq_valid, 1'b0);
    check("flp_vld", mif.out_valid, 1'b0);
    check("flp_rdy", mif.in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/memaccess.md
# memaccess

Memory-access stage between execute and writeback. Accepts one instruction at a time from execute and issues at most one data-bus transaction per memory instruction. Aligns and sign/zero-extends load data, and builds store strobes and lane-shifted store data. Holds a registered result (rd, data, pc, exception code) until writeback's `update` consumes it.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: execute presents an instruction.
- `in_ready` out 1: stage accepts an instruction this cycle.
- `in_pc` in 64: instruction PC.
- `in_is_load` in 1: load instruction.
- `in_is_store` in 1: store instruction. `in_is_load` and `in_is_store` are never both 1.
- `in_fun3` in 3: access width/sign (0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU).
- `in_addr` in 64: effective address, or ALU result for non-memory instructions.
- `in_wdata` in 64: store data, right-justified.
- `in_rd` in 5: destination register.
- `in_rd_en` in 1: instruction writes rd.
- `flush` in 1: discard in-flight instruction (trap/branch redirect).
- `dreq_valid` out 1: data-bus request valid.
- `dreq_addr` out 64: request address.
- `dreq_size` out 3: log2 bytes (0..3).
- `dreq_strobe` out 8: byte write enables; 0 for loads.
- `dreq_data` out 64: lane-aligned store data.
- `dresp_data_ok` in 1: bus transaction complete.
- `dresp_data` in 64: raw 8-byte-aligned read data.
- `out_valid` out 1: result valid for writeback.
- `out_ready` in 1: writeback `update`.
- `out_pc` out 64: PC of the result.
- `out_rd` out 5: destination register.
- `out_rd_en` out 1: destination write enable.
- `out_data` out 64: write-back data.
- `out_code` out 4: exception code, 0 = none.

## Operation
States: IDLE, BUS, HOLD, DRAIN.
- `in_ready` = (IDLE) | (HOLD & `out_ready`). Accept = `in_valid` & `in_ready` & !`flush`.
- Accept of a non-memory instruction: register `in_addr` as `out_data`, then go to HOLD.
- Accept of a load/store: register the fields, then go to BUS.
- BUS:
  - `dreq_valid`=1 with constant fields until `dresp_data_ok`.
  - `dreq_addr` = `in_addr` unchanged.
  - `dreq_size` = `fun3[1:0]`.
  - Store strobe = ((1<<(1<<size))-1) << `addr[2:0]`, truncated to 8 bits.
  - Store data = `wdata` << (8·`addr[2:0]`).
- `dresp_data_ok` in BUS → HOLD.
  - Load: `out_data` = (`dresp_data` >> 8·`addr[2:0]`), taken at width `fun3[1:0]`, sign-extended if `fun3[2]`=0, otherwise zero-extended.
  - Store: `out_data` = 0 and `out_rd_en` = 0.
- HOLD:
  - `out_valid`=1.
  - On `out_ready`: accept a new instruction if offered, otherwise go to IDLE.
  - Outputs are stable while `out_ready`=0.
- `flush`:
  - IDLE or HOLD → IDLE, `out_valid` dropped.
  - BUS → DRAIN. The bus request stays asserted until `dresp_data_ok`, then IDLE. Response data is discarded and no `out_valid` is produced.
  - `flush` has priority over a simultaneous accept.
- A `flush` in DRAIN has no further effect.

## Timing
- Reset values: state IDLE, `in_ready`=1, `dreq_valid`=0, `dreq_strobe`=0, `out_valid`=0. All other outputs 0.
- Non-memory latency: `out_valid` is 1 in the cycle after accept.
- Memory latency: `out_valid` is 1 in the cycle after `dresp_data_ok`. Minimum is 2 cycles after accept (`data_ok` in the first BUS cycle).
- Back-to-back throughput for non-memory instructions: 1 per cycle when `out_ready`=1.
- A reset mid-transaction drops the request immediately. Bus-side recovery is the bus owner's responsibility.

## Configuration
- `MEMACCESS_MISALIGN_TRAP_EN` defined:
  - An access with `addr` not aligned to its size goes straight to HOLD with no bus request.
  - `out_code` = 4 for a load, 6 for a store.
  - `out_rd_en` = 0, `out_data` = `in_addr` (trap value).
- Undefined:
  - No alignment check and `out_code` is always 0.
  - Strobe/lane shift bits beyond byte 7 are dropped.

## Test plan
- Sequence `in_addr`=0x1234 (non-memory), `out_ready`=1 → `out_valid` in the next cycle, `out_data`=0x1234.
- LB at `addr`=0x1003, `dresp_data`=0x00000000_80000000 → `out_data`=0xFFFFFFFF_FFFFFF80.
  - Same with LBU → 0x80.
- SH at `addr`=0x2002, `wdata`=0xBEEF → `dreq_strobe`=0x0C, `dreq_data`=0x0000_0000_BEEF_0000, `out_rd_en`=0.
- `dresp_data_ok` delayed 5 cycles → `dreq_valid` held 6 cycles with constant fields.
  - With `out_ready`=0 afterwards, `out_*` held and `in_ready`=0.
- `flush` in the 2nd BUS cycle, `data_ok` 3 cycles later → no `out_valid`, `in_ready`=1 in the cycle after `data_ok`.
- With `MEMACCESS_MISALIGN_TRAP_EN`, LW at 0x1002 → no `dreq_valid`, `out_code`=4, `out_data`=0x1002.
